// File: rtl/alu_instr_sequencer_if.sv
// Handshake and datapath strobe bundle between the ALU instruction sequencer
// (master) and the datapath / instruction source (slave).
interface alu_instr_sequencer_if #(
  parameter int DATA_WIDTH = 32,
  parameter int REG_ADDR_W = 4,
  parameter int OPC_WIDTH  = 5
) ();
  localparam int NUM_REGS = 2 ** REG_ADDR_W;

  logic                  start;
  logic                  mem_ready;
  logic [DATA_WIDTH-1:0] ir;
  logic                  busy;
  logic                  done;
  logic                  err;
  logic                  PCout;
  logic                  MARin;
  logic                  IncPC;
  logic                  Zin;
  logic                  ZLOout;
  logic                  ZHIout;
  logic                  PCin;
  logic                  Read;
  logic                  MDRin;
  logic                  MDRout;
  logic                  IRin;
  logic                  Yin;
  logic                  Loin;
  logic                  HIin;
  logic [NUM_REGS-1:0]   reg_in;
  logic [NUM_REGS-1:0]   reg_out;
  logic [OPC_WIDTH-1:0]  ALU_opcode;

  modport master (
    input  start, mem_ready, ir,
    output busy, done, err, PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
           Read, MDRin, MDRout, IRin, Yin, Loin, HIin, reg_in, reg_out, ALU_opcode
  );

  modport slave (
    output start, mem_ready, ir,
    input  busy, done, err, PCout, MARin, IncPC, Zin, ZLOout, ZHIout, PCin,
           Read, MDRin, MDRout, IRin, Yin, Loin, HIin, reg_in, reg_out, ALU_opcode
  );
endinterface

// File: rtl/alu_instr_sequencer.sv
// Fetch/execute control sequencer for register-register ALU instructions.
// Optional memory-wait timeout is enabled by defining MEM_TIMEOUT_EN.
//
// state | meaning
// IDLE  | waiting for start
// T0    | PC to MAR, increment PC into Z
// T1    | PC update, memory read (held while mem_ready low)
// T2    | MDR to IR
// T3    | opcode legality check, Rb into Y
// T4    | ALU operation into Z
// T5    | Z low result to Ra, or to LO for mul/div
// T6    | Z high result to HI (mul/div only)
// DONE  | completion pulse
// ERR   | illegal opcode / timeout pulse
module alu_instr_sequencer #(
  parameter int                   DATA_WIDTH     = 32,
  parameter int                   REG_ADDR_W     = 4,
  parameter int                   OPC_WIDTH      = 5,
  parameter logic [OPC_WIDTH-1:0] OP_MUL         = 5'b01111,
  parameter logic [OPC_WIDTH-1:0] OP_DIV         = 5'b10000,
  parameter logic [OPC_WIDTH-1:0] OP_NEG         = 5'b10001,
  parameter logic [OPC_WIDTH-1:0] OP_NOT         = 5'b10010,
  parameter int                   TIMEOUT_CYCLES = 16
) (
  input logic                    clk,
  input logic                    clr,
  alu_instr_sequencer_if.master  bus
);
  localparam int NUM_REGS = 2 ** REG_ADDR_W;
  localparam int OPC_LSB  = DATA_WIDTH - OPC_WIDTH;
  localparam int RA_LSB   = OPC_LSB - REG_ADDR_W;
  localparam int RB_LSB   = RA_LSB - REG_ADDR_W;
  localparam int RC_LSB   = RB_LSB - REG_ADDR_W;

  typedef enum logic [3:0] {
    S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_DONE, S_ERR
  } state_t;

  state_t state_q, state_d;
  logic   pcin_first_q, pcin_first_d;

  logic [OPC_WIDTH-1:0]  opc;
  logic [REG_ADDR_W-1:0] ra, rb, rc;
  logic                  is_binary, is_muldiv, is_unary, is_legal;
  logic                  unused_ir;

  assign opc       = bus.ir[OPC_LSB +: OPC_WIDTH];
  assign ra        = bus.ir[RA_LSB +: REG_ADDR_W];
  assign rb        = bus.ir[RB_LSB +: REG_ADDR_W];
  assign rc        = bus.ir[RC_LSB +: REG_ADDR_W];
  assign unused_ir = ^bus.ir[RC_LSB-1:0];

  assign is_binary = (opc >= OPC_WIDTH'(3)) && (opc <= OPC_WIDTH'(11));
  assign is_muldiv = (opc == OP_MUL) || (opc == OP_DIV);
  assign is_unary  = (opc == OP_NEG) || (opc == OP_NOT);
  assign is_legal  = is_binary || is_muldiv || is_unary;

`ifdef MEM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
`endif

  always_comb begin
    state_d      = state_q;
    pcin_first_d = 1'b0;
`ifdef MEM_TIMEOUT_EN
    wait_cnt_d   = wait_cnt_q;
`endif
    case (state_q)
      S_IDLE: if (bus.start) state_d = S_T0;
      S_T0: begin
        state_d      = S_T1;
        pcin_first_d = 1'b1;
`ifdef MEM_TIMEOUT_EN
        wait_cnt_d   = '0;
`endif
      end
      S_T1: begin
        if (bus.mem_ready) begin
          state_d = S_T2;
        end
`ifdef MEM_TIMEOUT_EN
        else begin
          // mem_ready on the limit cycle wins because it is tested first
          wait_cnt_d = wait_cnt_q + 1'b1;
          if (wait_cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) state_d = S_ERR;
        end
`endif
      end
      S_T2:    state_d = S_T3;
      S_T3:    state_d = is_legal ? S_T4 : S_ERR;
      S_T4:    state_d = S_T5;
      S_T5:    state_d = is_muldiv ? S_T6 : S_DONE;
      S_T6:    state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      S_ERR:   state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q      <= S_IDLE;
      pcin_first_q <= 1'b0;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q   <= '0;
`endif
    end else begin
      state_q      <= state_d;
      pcin_first_q <= pcin_first_d;
`ifdef MEM_TIMEOUT_EN
      wait_cnt_q   <= wait_cnt_d;
`endif
    end
  end

  always_comb begin
    bus.busy       = (state_q != S_IDLE);
    bus.done       = 1'b0;
    bus.err        = 1'b0;
    bus.PCout      = 1'b0;
    bus.MARin      = 1'b0;
    bus.IncPC      = 1'b0;
    bus.Zin        = 1'b0;
    bus.ZLOout     = 1'b0;
    bus.ZHIout     = 1'b0;
    bus.PCin       = 1'b0;
    bus.Read       = 1'b0;
    bus.MDRin      = 1'b0;
    bus.MDRout     = 1'b0;
    bus.IRin       = 1'b0;
    bus.Yin        = 1'b0;
    bus.Loin       = 1'b0;
    bus.HIin       = 1'b0;
    bus.reg_in     = '0;
    bus.reg_out    = '0;
    bus.ALU_opcode = '0;
    case (state_q)
      S_T0: begin
        bus.PCout = 1'b1;
        bus.MARin = 1'b1;
        bus.IncPC = 1'b1;
        bus.Zin   = 1'b1;
      end
      S_T1: begin
        bus.ZLOout = 1'b1;
        bus.PCin   = pcin_first_q;
        bus.Read   = 1'b1;
        bus.MDRin  = 1'b1;
      end
      S_T2: begin
        bus.MDRout = 1'b1;
        bus.IRin   = 1'b1;
      end
      S_T3: begin
        if (is_legal) begin
          bus.reg_out = NUM_REGS'(1) << rb;
          bus.Yin     = 1'b1;
        end
      end
      S_T4: begin
        bus.Zin        = 1'b1;
        bus.ALU_opcode = opc;
        bus.reg_out    = NUM_REGS'(1) << (is_unary ? rb : rc);
      end
      S_T5: begin
        bus.ZLOout = 1'b1;
        if (is_muldiv) bus.Loin = 1'b1;
        else           bus.reg_in = NUM_REGS'(1) << ra;
      end
      S_T6: begin
        bus.ZHIout = 1'b1;
        bus.HIin   = 1'b1;
      end
      S_DONE:  bus.done = 1'b1;
      S_ERR:   bus.err  = 1'b1;
      default: ;
    endcase
  end
endmodule
